// File: rtl/sodor_state_restore.sv
// sodor_state_restore: receives an architectural state snapshot as a stream of
// 32-bit words, stages it, verifies the header and XOR checksum, and commits the
// snapshot to flat *_state_dst outputs. A rejected frame never touches committed state.
module sodor_state_restore (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   input  logic          abort,
   output logic          busy,
   output logic          restore_done,
   output logic          restore_err,
   output logic [1:0]    err_code,
   output logic [1023:0] regfile_state_dst,
   output logic [31:0]   pc_reg_state_dst,
   output logic [31:0]   reg_mepc_state_dst,
   output logic [31:0]   reg_mcause_state_dst,
   output logic [31:0]   reg_mtval_state_dst,
   output logic [31:0]   reg_mscratch_state_dst,
   output logic [31:0]   reg_mtvec_state_dst,
   output logic [31:0]   reg_mie_state_dst,
   output logic [31:0]   reg_dpc_state_dst,
   output logic [31:0]   reg_dscratch_state_dst
);

   localparam logic [15:0]  MAGIC     = 16'h5D0C;
   localparam int unsigned  NUM_GPR   = 32;
   localparam int unsigned  NUM_CSR   = 9;
   localparam logic [7:0]   FRAME_CNT = 8'(NUM_GPR + NUM_CSR);
   localparam logic [4:0]   GPR_LAST  = 5'(NUM_GPR - 1);
   localparam logic [4:0]   CSR_LAST  = 5'(NUM_CSR - 1);

   localparam logic [1:0]   ERR_MAGIC = 2'b01;
   localparam logic [1:0]   ERR_COUNT = 2'b10;
   localparam logic [1:0]   ERR_CSUM  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GPR,
      S_CSR,
      S_CHK,
      S_COMMIT
   } state_t;

   state_t      state;
   logic        ready_q;
   logic [4:0]  idx;
   logic [31:0] acc;
   logic [31:0] stage_gpr [NUM_GPR];
   logic [31:0] stage_csr [NUM_CSR];
   logic        xfer;

   // Abort must stall the word presented in the same cycle, so it gates ready directly.
   assign in_ready = ready_q & ~abort;
   assign xfer     = in_valid & in_ready;

   // Frame sequencer: header check, staging, checksum verify and commit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                  <= S_IDLE;
         ready_q                <= 1'b0;
         idx                    <= '0;
         acc                    <= '0;
         busy                   <= 1'b0;
         restore_done           <= 1'b0;
         restore_err            <= 1'b0;
         err_code               <= '0;
         regfile_state_dst      <= '0;
         pc_reg_state_dst       <= '0;
         reg_mepc_state_dst     <= '0;
         reg_mcause_state_dst   <= '0;
         reg_mtval_state_dst    <= '0;
         reg_mscratch_state_dst <= '0;
         reg_mtvec_state_dst    <= '0;
         reg_mie_state_dst      <= '0;
         reg_dpc_state_dst      <= '0;
         reg_dscratch_state_dst <= '0;
         for (int unsigned i = 0; i < NUM_GPR; i++) stage_gpr[i] <= '0;
         for (int unsigned k = 0; k < NUM_CSR; k++) stage_csr[k] <= '0;
      end else begin
         restore_done <= 1'b0;
         restore_err  <= 1'b0;
         if (abort && (state != S_COMMIT)) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
            idx     <= '0;
            acc     <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  ready_q <= 1'b1;
                  if (xfer) begin
                     if (in_data[31:16] != MAGIC) begin
                        err_code    <= ERR_MAGIC;
                        restore_err <= 1'b1;
                     end else if (in_data[15:8] != FRAME_CNT) begin
                        err_code    <= ERR_COUNT;
                        restore_err <= 1'b1;
                     end else begin
                        state <= S_GPR;
                        busy  <= 1'b1;
                        idx   <= '0;
                        acc   <= '0;
                     end
                  end
               end
               S_GPR: begin
                  if (xfer) begin
                     // x0 is hardwired zero but its word still contributes to the checksum.
                     stage_gpr[idx] <= (idx == 5'd0) ? 32'd0 : in_data;
                     acc            <= acc ^ in_data;
                     if (idx == GPR_LAST) begin
                        idx   <= '0;
                        state <= S_CSR;
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end
               end
               S_CSR: begin
                  if (xfer) begin
                     stage_csr[idx[3:0]] <= in_data;
                     acc                 <= acc ^ in_data;
                     if (idx == CSR_LAST) begin
                        idx   <= '0;
                        state <= S_CHK;
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end
               end
               S_CHK: begin
                  if (xfer) begin
                     if (in_data == acc) begin
                        state        <= S_COMMIT;
                        ready_q      <= 1'b0;
                        restore_done <= 1'b1;
                     end else begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        err_code    <= ERR_CSUM;
                        restore_err <= 1'b1;
                     end
                  end
               end
               S_COMMIT: begin
                  for (int unsigned i = 0; i < NUM_GPR; i++)
                     regfile_state_dst[32*i +: 32] <= stage_gpr[i];
                  pc_reg_state_dst       <= stage_csr[0];
                  reg_mepc_state_dst     <= stage_csr[1];
                  reg_mcause_state_dst   <= stage_csr[2];
                  reg_mtval_state_dst    <= stage_csr[3];
                  reg_mscratch_state_dst <= stage_csr[4];
                  reg_mtvec_state_dst    <= stage_csr[5];
                  reg_mie_state_dst      <= stage_csr[6];
                  reg_dpc_state_dst      <= stage_csr[7];
                  reg_dscratch_state_dst <= stage_csr[8];
                  state                  <= S_IDLE;
                  busy                   <= 1'b0;
                  ready_q                <= 1'b1;
                  acc                    <= '0;
               end
               default: begin
                  state   <= S_IDLE;
                  busy    <= 1'b0;
                  ready_q <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sodor_state_restore.sv
// Bench for sodor_state_restore: builds frames from plain arrays, keeps the
// expected committed snapshot in arrays, and compares the DUT against it.
module tb_sodor_state_restore;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          abort;
   logic          busy;
   logic          restore_done;
   logic          restore_err;
   logic [1:0]    err_code;
   logic [1023:0] regfile_state_dst;
   logic [31:0]   pc_reg_state_dst;
   logic [31:0]   reg_mepc_state_dst;
   logic [31:0]   reg_mcause_state_dst;
   logic [31:0]   reg_mtval_state_dst;
   logic [31:0]   reg_mscratch_state_dst;
   logic [31:0]   reg_mtvec_state_dst;
   logic [31:0]   reg_mie_state_dst;
   logic [31:0]   reg_dpc_state_dst;
   logic [31:0]   reg_dscratch_state_dst;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame under construction and expected committed state.
   logic [31:0] f_words [43];
   logic [31:0] exp_regs [32];
   logic [31:0] exp_csr  [9];   // pc, mepc, mcause, mtval, mscratch, mtvec, mie, dpc, dscratch
   logic [1:0]  exp_err;

   sodor_state_restore dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .in_valid               (in_valid),
      .in_ready               (in_ready),
      .in_data                (in_data),
      .abort                  (abort),
      .busy                   (busy),
      .restore_done           (restore_done),
      .restore_err            (restore_err),
      .err_code               (err_code),
      .regfile_state_dst      (regfile_state_dst),
      .pc_reg_state_dst       (pc_reg_state_dst),
      .reg_mepc_state_dst     (reg_mepc_state_dst),
      .reg_mcause_state_dst   (reg_mcause_state_dst),
      .reg_mtval_state_dst    (reg_mtval_state_dst),
      .reg_mscratch_state_dst (reg_mscratch_state_dst),
      .reg_mtvec_state_dst    (reg_mtvec_state_dst),
      .reg_mie_state_dst      (reg_mie_state_dst),
      .reg_dpc_state_dst      (reg_dpc_state_dst),
      .reg_dscratch_state_dst (reg_dscratch_state_dst)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare every committed output and the held error code against the model.
   task automatic check_outputs(input string tag);
      logic [31:0] csr_got [9];
      csr_got[0] = pc_reg_state_dst;      csr_got[1] = reg_mepc_state_dst;
      csr_got[2] = reg_mcause_state_dst;  csr_got[3] = reg_mtval_state_dst;
      csr_got[4] = reg_mscratch_state_dst; csr_got[5] = reg_mtvec_state_dst;
      csr_got[6] = reg_mie_state_dst;     csr_got[7] = reg_dpc_state_dst;
      csr_got[8] = reg_dscratch_state_dst;
      for (int i = 0; i < 32; i++)
         check($sformatf("%s x%0d", tag, i), regfile_state_dst[32*i +: 32], exp_regs[i]);
      for (int k = 0; k < 9; k++)
         check($sformatf("%s csr%0d", tag, k), csr_got[k], exp_csr[k]);
      check({tag, " err_code"}, 32'(err_code), 32'(exp_err));
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) exp_regs[i] = '0;
      for (int k = 0; k < 9; k++) exp_csr[k] = '0;
      exp_err = '0;
   endtask

   // Build a 43-word frame; rnd selects random register contents.
   task automatic build_frame(input logic [31:0] pc_v, input bit rnd);
      logic [31:0] x;
      f_words[0] = {16'h5D0C, 8'd41, rnd ? 8'($urandom) : 8'h00};
      for (int i = 0; i < 32; i++) f_words[1 + i] = rnd ? $urandom : 32'h1000_0000 + 32'(i);
      f_words[33] = pc_v;
      for (int k = 0; k < 8; k++) f_words[34 + k] = rnd ? $urandom : 32'hC5C5_0000 + 32'(k);
      x = '0;
      for (int i = 1; i <= 41; i++) x = x ^ f_words[i];
      f_words[42] = x;
   endtask

   // Present one word (with optional idle gaps) and return just after it is taken.
   task automatic send_word(input logic [31:0] w, input bit gaps);
      int guard = 0;
      if (gaps) begin
         while ($urandom_range(1, 0) == 1 && guard < 4) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(negedge clock);
            guard++;
         end
      end
      in_valid = 1'b1;
      in_data  = w;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (!in_ready) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic send_words(input int first, input int last, input bit gaps);
      for (int i = first; i <= last; i++) send_word(f_words[i], gaps);
   endtask

   // Send the built frame completely and expect a commit.
   task automatic send_good(input string tag, input bit gaps);
      send_words(0, 42, gaps);
      check({tag, " done"}, 32'(restore_done), 32'd1);
      check({tag, " err_pulse"}, 32'(restore_err), 32'd0);
      check({tag, " ready_commit"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < 32; i++) exp_regs[i] = (i == 0) ? 32'd0 : f_words[1 + i];
      for (int k = 0; k < 9; k++) exp_csr[k] = f_words[33 + k];
      @(negedge clock);
      check({tag, " done_drop"}, 32'(restore_done), 32'd0);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      check_outputs(tag);
   endtask

   // Check the one-cycle error pulse just after the offending transfer.
   task automatic expect_err(input string tag, input logic [1:0] code);
      exp_err = code;
      check({tag, " err_pulse"}, 32'(restore_err), 32'd1);
      check({tag, " done"}, 32'(restore_done), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      @(negedge clock);
      check({tag, " err_drop"}, 32'(restore_err), 32'd0);
      check_outputs(tag);
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      abort    = 1'b0;
      clear_model();
      repeat (3) @(negedge clock);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst pulses", 32'({restore_done, restore_err}), 32'd0);
      check_outputs("rst");
      reset_n = 1'b1;
      @(negedge clock);

      // T1 reference frame, continuous valid
      build_frame(32'h8000_0040, 1'b0);
      send_good("T1", 1'b0);
      check("T1 x5", regfile_state_dst[32*5 +: 32], 32'h1000_0005);

      // T3 corrupted checksum leaves T1 state in place
      f_words[42] = f_words[42] ^ 32'h1;
      send_words(0, 42, 1'b0);
      expect_err("T3", 2'b11);

      // T2 bad magic, then bad count
      send_word(32'hDEAD_2900, 1'b0);
      expect_err("T2 magic", 2'b01);
      send_word(32'h5D0C_2800, 1'b0);
      expect_err("T2 count", 2'b10);

      // T4 reference frame with random gaps, then random frames
      build_frame(32'h8000_0040, 1'b0);
      send_good("T4", 1'b1);
      for (int r = 0; r < 4; r++) begin
         build_frame($urandom, 1'b1);
         send_good($sformatf("T4r%0d", r), 1'b1);
      end

      // T5 abort after W20, then a fresh frame
      build_frame(32'h0000_0300, 1'b1);
      send_words(0, 20, 1'b0);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      #1;
      check("T5 ready_abort", 32'(in_ready), 32'd0);
      @(negedge clock);
      abort    = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("T5 pulses%0d", c), 32'({restore_done, restore_err}), 32'd0);
         check($sformatf("T5 busy%0d", c), 32'(busy), 32'd0);
         @(negedge clock);
      end
      check_outputs("T5 hold");
      build_frame(32'h0000_0200, 1'b0);
      send_good("T5", 1'b0);
      check("T5 pc", pc_reg_state_dst, 32'h0000_0200);

      // T6 asynchronous reset in the CSR phase
      build_frame(32'h8000_0040, 1'b1);
      send_words(0, 35, 1'b0);
      check("T6 busy_pre", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      clear_model();
      check("T6 busy", 32'(busy), 32'd0);
      check("T6 in_ready", 32'(in_ready), 32'd0);
      check_outputs("T6 rst");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      build_frame(32'h8000_0040, 1'b0);
      send_good("T6", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Pulses must never overlap.
   always @(negedge clock) begin
      if (reset_n && restore_done && restore_err) begin
         n_tests++;
         n_fail++;
         $display("FAIL pulse_overlap: done %b err %b required not both", restore_done, restore_err);
      end
   end

endmodule
